gbfwei_fifo_ctrl: RTL
=====================

# gbfwei_fifo_ctrl

Circular-buffer controller that sits directly in front of the weight global-buffer RAM wrapper (single-port, write-priority address mux, 1-cycle registered read). Accepts a valid/ready weight stream from the DRAM loader, writes it into the RAM and presents the stored words in FIFO order as a valid/ready stream to the PE weight distributor. The RAM is single-port, so the controller owns the port arbitration and never asserts read and write in the same cycle.

## Interface
- SRAM_DEPTH_BIT, 6, RAM address width
- SRAM_DEPTH, 2**SRAM_DEPTH_BIT, RAM entries
- SRAM_WIDTH, 28, word width
- clk  in  1  clock, all logic on posedge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  upstream word valid
- in_ready  out  1  controller accepts word this cycle
- in_data  in  SRAM_WIDTH  upstream word
- out_valid  out  1  out_data holds the head word
- out_ready  in  1  downstream consumes head word
- out_data  out  SRAM_WIDTH  head word, driven from ram_data_out
- occupancy  out  SRAM_DEPTH_BIT+1  words in RAM plus out_valid
- ram_addr_w, ram_addr_r  out  SRAM_DEPTH_BIT  RAM write/read addresses
- ram_write_en, ram_read_en  out  1  RAM strobes, mutually exclusive
- ram_data_in  out  SRAM_WIDTH  RAM write data (= in_data)
- ram_data_out  in  SRAM_WIDTH  RAM read data, valid 1 cycle after ram_read_en

## Operation
- State: wr_ptr, rd_ptr (SRAM_DEPTH_BIT, natural wrap at SRAM_DEPTH), ram_cnt (0..SRAM_DEPTH), out_valid, last_grant (WR/RD).
- Write request: in_valid && ram_cnt != SRAM_DEPTH. Read request: ram_cnt != 0 && (!out_valid || out_ready).
- Arbitration: one request -> grant it. Both -> round-robin, grant the side not equal to last_grant; last_grant updates only on contended cycles.
- in_ready = write request && write granted (combinational). Write: ram_write_en=1, ram_addr_w=wr_ptr, wr_ptr+1.
- Read grant: ram_read_en=1, ram_addr_r=rd_ptr, rd_ptr+1, out_valid<=1 next cycle.
- out_valid && out_ready with no read granted -> out_valid<=0. No read is ever issued while out_valid && !out_ready, so the RAM output register holds the head word stable.
- ram_cnt: +1 on write only, -1 on read only, unchanged otherwise (the two never happen together).
- occupancy = ram_cnt + out_valid, maximum SRAM_DEPTH+1.
- Full: ram_cnt == SRAM_DEPTH blocks writes (in_ready=0); reads still proceed. Empty: ram_cnt == 0 blocks reads; out_valid may still be 1.

## Timing
- Reset values: wr_ptr=rd_ptr=0, ram_cnt=0, out_valid=0, last_grant=RD (the first contended cycle grants WR), in_ready=0 during rst, occupancy=0.
- rst mid-operation discards all stored words. RAM contents are undefined but unreachable.
- Write-to-out latency on an empty buffer: word accepted in cycle t, read granted in t+1, out_valid=1 in t+2.
- Streaming out alone: 1 word/cycle. Streaming in alone: 1 word/cycle. Both saturated: each side gets 1 word per 2 cycles.

## Configuration
- GBFWEI_FLUSH_EN defined: adds input flush (1 bit).
  - flush has the same effect as rst on pointers, ram_cnt, out_valid and last_grant.
  - in_ready=0 and no RAM strobes in the flush cycle.
  - rst has priority over flush.
- GBFWEI_FLUSH_EN undefined: the flush port does not exist and the logic is absent.

## Structure
- Package gbfwei_pkg:
  - default SRAM_DEPTH_BIT/SRAM_WIDTH constants
  - grant_t enum {GNT_WR, GNT_RD}
- Sub-module gbfwei_arb: 2-way round-robin arbiter with the last_grant register.
  - Inputs: clk, rst, req_wr, req_rd.
  - Outputs: gnt_wr, gnt_rd.

## Test plan
- Reset, then write 3 words 0xA1,0xA2,0xA3 with out_ready=0:
  - in_ready=1 for 3 cycles
  - out_valid rises 2 cycles after the first write, with out_data=0xA1
  - occupancy=3
- Fill to 65 words with out_ready=0:
  - occupancy=65, in_ready=0
  - ram_write_en never asserted after the 64th RAM write
- Concurrent saturated in/out with an incrementing pattern:
  - grants alternate WR/RD
  - output sequence is in order with no gaps or repeats
  - ram_write_en and ram_read_en are never both 1
- Wrap-around: push and pop 200 words at random valid/ready rates.
  - Scoreboard matches all 200 words.
  - rd_ptr/wr_ptr pass 63->0 several times.
- Backpressure hold: with out_valid=1, hold out_ready=0 for 10 cycles while writing.
  - out_data stays constant.
  - No ram_read_en during the hold.
- Assert rst with 5 words stored:
  - next cycle out_valid=0, occupancy=0
  - a following write of 0xB0 emerges first
  - with GBFWEI_FLUSH_EN, repeat using flush for the same response.

Source files
------------

// File: rtl/gbfwei_pkg.sv
// Shared defaults and types for the weight global-buffer FIFO controller.
package gbfwei_pkg;

    // Default RAM geometry: 64 entries of 28-bit weight words.
    localparam int DEF_SRAM_DEPTH_BIT = 6;
    localparam int DEF_SRAM_WIDTH     = 28;

    // Which side of the single RAM port won the most recent contended cycle.
    typedef enum logic {
        GNT_WR = 1'b0,
        GNT_RD = 1'b1
    } grant_t;

endpackage

// File: rtl/gbfwei_arb.sv
// Two-way round-robin arbiter for the single RAM port.
// An uncontested request is granted directly; when both sides request, the
// side that did not win the previous contended cycle is granted. The
// last-grant memory only moves on contended cycles.
module gbfwei_arb
    import gbfwei_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_wr,
    input  logic req_rd,
    output logic gnt_wr,
    output logic gnt_rd
);

    grant_t last_grant_q;
    grant_t last_grant_d;

    // Grant decision and next value of the round-robin memory.
    always_comb begin
        // NOTE: every signal assigned here gets a value before any branch,
        // so no path leaves it unassigned and no latch is inferred.
        gnt_wr       = req_wr && (!req_rd || (last_grant_q == GNT_RD));
        gnt_rd       = req_rd && (!req_wr || (last_grant_q == GNT_WR));
        last_grant_d = last_grant_q;
        if (req_wr && req_rd) begin
            last_grant_d = gnt_wr ? GNT_WR : GNT_RD;
        end
    end

    // Round-robin memory; reset favours the write side on the first contest.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples values from before the edge, independent of block order.
        if (rst) begin
            last_grant_q <= GNT_RD;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/gbfwei_fifo_ctrl.sv
// Circular-buffer controller in front of the single-port weight global-buffer
// RAM. Accepts a valid/ready weight stream, writes it into the RAM and
// replays it in FIFO order as a valid/ready stream. The RAM has a 1-cycle
// registered read, so a read is only issued when the output slot is empty or
// being consumed; this keeps the RAM output register stable as the head word.
// Optional build macro: GBFWEI_FLUSH_EN adds a 'flush' input that clears the
// controller like rst does.
module gbfwei_fifo_ctrl
    import gbfwei_pkg::*;
#(
    parameter int SRAM_DEPTH_BIT = DEF_SRAM_DEPTH_BIT,
    parameter int SRAM_WIDTH     = DEF_SRAM_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
`ifdef GBFWEI_FLUSH_EN
    input  logic                      flush,
`endif
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SRAM_WIDTH-1:0]     in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SRAM_WIDTH-1:0]     out_data,
    output logic [SRAM_DEPTH_BIT:0]   occupancy,
    output logic [SRAM_DEPTH_BIT-1:0] ram_addr_w,
    output logic [SRAM_DEPTH_BIT-1:0] ram_addr_r,
    output logic                      ram_write_en,
    output logic                      ram_read_en,
    output logic [SRAM_WIDTH-1:0]     ram_data_in,
    input  logic [SRAM_WIDTH-1:0]     ram_data_out
);

    localparam int                        SRAM_DEPTH = 2 ** SRAM_DEPTH_BIT;
    localparam int                        CNT_W      = SRAM_DEPTH_BIT + 1;
    localparam logic [CNT_W-1:0]          CNT_FULL   = CNT_W'(SRAM_DEPTH);
    localparam logic [CNT_W-1:0]          CNT_ONE    = CNT_W'(1);
    localparam logic [SRAM_DEPTH_BIT-1:0] PTR_ONE    = SRAM_DEPTH_BIT'(1);

    // Combined clear: rst, and flush when the feature is built in.
    logic clr;
`ifdef GBFWEI_FLUSH_EN
    assign clr = rst || flush;
`else
    assign clr = rst;
`endif

    logic [SRAM_DEPTH_BIT-1:0] wr_ptr_q, wr_ptr_d;
    logic [SRAM_DEPTH_BIT-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]          ram_cnt_q, ram_cnt_d;
    logic                      out_valid_q, out_valid_d;
    logic                      req_wr, req_rd;
    logic                      gnt_wr, gnt_rd;

    // Port requests; both are suppressed in a clear cycle so no strobe leaks.
    always_comb begin
        req_wr = !clr && in_valid && (ram_cnt_q != CNT_FULL);
        req_rd = !clr && (ram_cnt_q != '0) && (!out_valid_q || out_ready);
    end

    gbfwei_arb u_arb (
        .clk    (clk),
        .rst    (clr),
        .req_wr (req_wr),
        .req_rd (req_rd),
        .gnt_wr (gnt_wr),
        .gnt_rd (gnt_rd)
    );

    // Pointer, count and output-slot updates from the granted operation.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ram_cnt_d   = ram_cnt_q;
        out_valid_d = out_valid_q;
        if (gnt_wr) begin
            wr_ptr_d  = wr_ptr_q + PTR_ONE;
            ram_cnt_d = ram_cnt_q + CNT_ONE;
        end
        if (gnt_rd) begin
            rd_ptr_d    = rd_ptr_q + PTR_ONE;
            ram_cnt_d   = ram_cnt_q - CNT_ONE;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Controller state registers.
    always_ff @(posedge clk) begin
        // NOTE: the RAM array itself is never cleared; zeroing the pointers
        // and count is enough because stale entries become unreachable.
        if (clr) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ram_cnt_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_cnt_q   <= ram_cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready     = gnt_wr;
    assign ram_write_en = gnt_wr;
    assign ram_read_en  = gnt_rd;
    assign ram_addr_w   = wr_ptr_q;
    assign ram_addr_r   = rd_ptr_q;
    assign ram_data_in  = in_data;
    assign out_valid    = out_valid_q;
    assign out_data     = ram_data_out;
    assign occupancy    = ram_cnt_q + CNT_W'(out_valid_q);

endmodule
